// File: rtl/time_keeper_if.sv
// Button inputs and time/mode display outputs of the time keeper, grouped as one bundle.
interface time_keeper_if;
  logic       BTN_MODE;
  logic       BTN_INC;
  logic [5:0] seconds;
  logic [5:0] minutes;
  logic [4:0] hours;
  logic [1:0] mode;
  logic       sec_tick;

  modport master (
    output BTN_MODE, BTN_INC,
    input  seconds, minutes, hours, mode, sec_tick
  );

  modport slave (
    input  BTN_MODE, BTN_INC,
    output seconds, minutes, hours, mode, sec_tick
  );
endinterface

// File: rtl/time_keeper.sv
// 24-hour clock with a one-second prescaler, two debounced buttons and a RUN/SET_HR/SET_MIN mode machine.
module time_keeper #(
  parameter int CLK_HZ          = 100000000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic         CLK,
  input  logic         RST_BTN,
  time_keeper_if.slave tk
);
  localparam int PSW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [PSW-1:0] PS_MAX = PSW'(CLK_HZ - 1);
  localparam logic [DBW-1:0] DB_MAX = DBW'(DEBOUNCE_CYCLES - 1);
  localparam int MODE_IDX = 0;
  localparam int INC_IDX  = 1;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10
  } mode_e;

  function automatic logic [5:0] inc_mod60(input logic [5:0] v);
    if (v >= 6'd59) begin
      inc_mod60 = 6'd0;
    end else begin
      inc_mod60 = v + 6'd1;
    end
  endfunction

  function automatic logic [4:0] inc_mod24(input logic [4:0] v);
    if (v >= 5'd23) begin
      inc_mod24 = 5'd0;
    end else begin
      inc_mod24 = v + 5'd1;
    end
  endfunction

  logic [1:0]             raw_s;
  logic [1:0]             sync1_q;
  logic [1:0]             sync2_q;
  logic [1:0][DBW-1:0]    cnt_q;
  logic [1:0][DBW-1:0]    cnt_d;
  logic [1:0]             db_q;
  logic [1:0]             db_d;
  logic [1:0]             press_q;
  logic [1:0]             press_d;

  mode_e                  state_q;
  mode_e                  state_d;
  logic [PSW-1:0]         presc_q;
  logic [PSW-1:0]         presc_d;
  logic [5:0]             sec_q;
  logic [5:0]             sec_d;
  logic [5:0]             min_q;
  logic [5:0]             min_d;
  logic [4:0]             hr_q;
  logic [4:0]             hr_d;
  logic                   tick_q;
  logic                   tick_d;
  logic                   mode_ev_s;
  logic                   inc_ev_s;

  assign raw_s[MODE_IDX] = tk.BTN_MODE;
  assign raw_s[INC_IDX]  = tk.BTN_INC;

  // Two-flop synchronizers for the asynchronous raw buttons.
  always_ff @(posedge CLK) begin
    if (RST_BTN) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= raw_s;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: flip the stable state after DEBOUNCE_CYCLES opposite samples; a rising flip yields a press.
  always_comb begin
    cnt_d   = cnt_q;
    db_d    = db_q;
    press_d = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == DB_MAX) begin
          cnt_d[i]   = '0;
          db_d[i]    = sync2_q[i];
          press_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DBW'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  // Debounce state; the press pulse is registered, adding the final cycle of button latency.
  always_ff @(posedge CLK) begin
    if (RST_BTN) begin
      cnt_q   <= '0;
      db_q    <= 2'b00;
      press_q <= 2'b00;
    end else begin
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      press_q <= press_d;
    end
  end

  assign mode_ev_s = press_q[MODE_IDX];
  assign inc_ev_s  = press_q[INC_IDX];

  // Mode machine and time fields; a mode press always wins over a simultaneous inc press.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hr_d    = hr_q;
    tick_d  = 1'b0;
    case (state_q)
      RUN: begin
        if (mode_ev_s) begin
          state_d = SET_HR;
          presc_d = '0;
        end else if (presc_q == PS_MAX) begin
          presc_d = '0;
          tick_d  = 1'b1;
          sec_d   = inc_mod60(sec_q);
          if (sec_q == 6'd59) begin
            min_d = inc_mod60(min_q);
            if (min_q == 6'd59) begin
              hr_d = inc_mod24(hr_q);
            end else begin
              hr_d = hr_q;
            end
          end else begin
            min_d = min_q;
          end
        end else begin
          presc_d = presc_q + PSW'(1);
        end
      end
      SET_HR: begin
        presc_d = '0;
        if (mode_ev_s) begin
          state_d = SET_MIN;
        end else if (inc_ev_s) begin
          hr_d = inc_mod24(hr_q);
        end else begin
          state_d = SET_HR;
        end
      end
      SET_MIN: begin
        presc_d = '0;
        if (mode_ev_s) begin
          state_d = RUN;
          sec_d   = 6'd0;
        end else if (inc_ev_s) begin
          min_d = inc_mod60(min_q);
        end else begin
          state_d = SET_MIN;
        end
      end
      default: begin
        state_d = RUN;
        presc_d = '0;
      end
    endcase
  end

  // Mode state register.
  always_ff @(posedge CLK) begin
    if (RST_BTN) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Prescaler, time fields and the registered second tick.
  always_ff @(posedge CLK) begin
    if (RST_BTN) begin
      presc_q <= '0;
      sec_q   <= 6'd0;
      min_q   <= 6'd0;
      hr_q    <= 5'd0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hr_q    <= hr_d;
      tick_q  <= tick_d;
    end
  end

  assign tk.seconds  = sec_q;
  assign tk.minutes  = min_q;
  assign tk.hours    = hr_q;
  assign tk.mode     = state_q;
  assign tk.sec_tick = tick_q;
endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper with CLK_HZ=10 and DEBOUNCE_CYCLES=4.
module tb_time_keeper;
  localparam int HZ = 10;
  localparam int DB = 4;
  localparam int BTN_MODE = 0;
  localparam int BTN_INC  = 1;
  localparam int BTN_BOTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   ncyc = 0;
  int   s_start;

  time_keeper_if tk ();

  time_keeper #(.CLK_HZ(HZ), .DEBOUNCE_CYCLES(DB)) dut (
    .CLK     (clk),
    .RST_BTN (rst),
    .tk      (tk)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ncyc <= ncyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_time(input string tag, input int h, input int m, input int s);
    check({tag, ".hours"},   32'(tk.hours),   32'(h));
    check({tag, ".minutes"}, 32'(tk.minutes), 32'(m));
    check({tag, ".seconds"}, 32'(tk.seconds), 32'(s));
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input int idx, input logic v);
    if (idx == BTN_MODE || idx == BTN_BOTH) tk.BTN_MODE = v;
    if (idx == BTN_INC  || idx == BTN_BOTH) tk.BTN_INC  = v;
  endtask

  task automatic press(input int idx, input int hold);
    set_btn(idx, 1'b1);
    cycles(hold);
    set_btn(idx, 1'b0);
    cycles(12);
  endtask

  task automatic wait_until(input int target);
    while (ncyc < target) cycles(1);
  endtask

  initial begin
    tk.BTN_MODE = 1'b0;
    tk.BTN_INC  = 1'b0;
    rst = 1'b1;
    cycles(3);
    check_time("reset", 0, 0, 0);
    check("reset.mode", 32'(tk.mode), 32'd0);
    check("reset.tick", 32'(tk.sec_tick), 32'd0);

    // Free run from reset release: ticks every 10 cycles.
    rst = 1'b0;
    cycles(9);
    check("tick_before_10", 32'(tk.sec_tick), 32'd0);
    check("sec_before_10", 32'(tk.seconds), 32'd0);
    cycles(1);
    check("tick_at_10", 32'(tk.sec_tick), 32'd1);
    check("sec_at_10", 32'(tk.seconds), 32'd1);
    cycles(1);
    check("tick_one_cycle", 32'(tk.sec_tick), 32'd0);
    cycles(9);
    check("tick_at_20", 32'(tk.sec_tick), 32'd1);
    check("sec_at_20", 32'(tk.seconds), 32'd2);

    // Inc is ignored in RUN.
    press(BTN_INC, 8);
    check_time("run_inc_ignored", 0, 0, 4);
    check("run_inc_mode", 32'(tk.mode), 32'd0);

    press(BTN_MODE, 8);
    check("enter_set_hr", 32'(tk.mode), 32'd1);
    check("set_hr_sec_held", 32'(tk.seconds), 32'd4);
    check("set_hr_tick_low", 32'(tk.sec_tick), 32'd0);

    for (int i = 0; i < 23; i++) press(BTN_INC, 8);
    check_time("hours_23", 23, 0, 4);
    press(BTN_INC, 8);
    check_time("hours_wrap", 0, 0, 4);
    for (int i = 0; i < 23; i++) press(BTN_INC, 8);
    check("hours_back_23", 32'(tk.hours), 32'd23);

    // Simultaneous mode and inc: mode wins.
    press(BTN_BOTH, 8);
    check("both_mode", 32'(tk.mode), 32'd2);
    check("both_hours", 32'(tk.hours), 32'd23);

    press(BTN_INC, 3);
    check("short_glitch", 32'(tk.minutes), 32'd0);

    set_btn(BTN_INC, 1'b1);
    cycles(6);
    check("latency_6", 32'(tk.minutes), 32'd0);
    cycles(1);
    check("latency_7", 32'(tk.minutes), 32'd1);
    cycles(1);
    set_btn(BTN_INC, 1'b0);
    cycles(12);

    press(BTN_INC, 50);
    check("hold_one_event", 32'(tk.minutes), 32'd2);

    for (int i = 0; i < 57; i++) press(BTN_INC, 8);
    check_time("minutes_59", 23, 59, 4);
    press(BTN_INC, 8);
    check_time("minutes_wrap", 23, 0, 4);
    for (int i = 0; i < 59; i++) press(BTN_INC, 8);
    check("minutes_back_59", 32'(tk.minutes), 32'd59);

    // Return to RUN clears seconds, then run a full minute to the midnight cascade.
    set_btn(BTN_MODE, 1'b1);
    cycles(7);
    check("back_to_run", 32'(tk.mode), 32'd0);
    check_time("run_entry", 23, 59, 0);
    cycles(1);
    set_btn(BTN_MODE, 1'b0);
    cycles(598);
    check_time("pre_midnight", 23, 59, 59);
    cycles(1);
    check_time("midnight", 0, 0, 0);
    check("midnight_tick", 32'(tk.sec_tick), 32'd1);

    // Build 12:34:56 in SET_MIN.
    press(BTN_MODE, 8);
    for (int i = 0; i < 12; i++) press(BTN_INC, 8);
    press(BTN_MODE, 8);
    for (int i = 0; i < 34; i++) press(BTN_INC, 8);
    check_time("set_12_34", 12, 34, 0);
    s_start = ncyc;
    set_btn(BTN_MODE, 1'b1);
    cycles(8);
    set_btn(BTN_MODE, 1'b0);
    wait_until(s_start + 565);
    press(BTN_MODE, 8);
    check("mid_set_hr", 32'(tk.mode), 32'd1);
    check("mid_sec_56", 32'(tk.seconds), 32'd56);
    press(BTN_MODE, 8);
    check("mid_set_min", 32'(tk.mode), 32'd2);
    check_time("pre_reset", 12, 34, 56);

    // One-cycle reset pulse from SET_MIN.
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    check_time("reset_pulse", 0, 0, 0);
    check("reset_pulse_mode", 32'(tk.mode), 32'd0);
    cycles(9);
    check("post_reset_tick_9", 32'(tk.sec_tick), 32'd0);
    cycles(1);
    check("post_reset_tick_10", 32'(tk.sec_tick), 32'd1);
    check("post_reset_sec", 32'(tk.seconds), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
